// File: rtl/tdc_stream_tx.sv
// tdc_stream_tx: assembles up to three TDC hits per shot into a frame FIFO and streams each shot as a valid/ready burst.
// Optional TDC_TX_EMPTY_BEAT_EN: zero-hit shots are committed and sent as a single num=0 beat.
module tdc_stream_tx #(
    parameter int FDEPTH = 2,
    parameter int DW     = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          tx_en,
    input  logic          shot_start,
    input  logic          shot_end,
    input  logic          hit_valid,
    input  logic [DW-1:0] hit_time,
    input  logic [3:0]    hit_int,
    output logic [DW-1:0] TDC_Odata,
    output logic [3:0]    TDC_Oint,
    output logic [1:0]    TDC_Onum,
    output logic          TDC_Ovalid,
    output logic          TDC_Olast,
    input  logic          TDC_Oready,
    output logic [7:0]    drop_cnt,
    output logic          busy
);
    localparam int AW = $clog2(FDEPTH);
    localparam logic [AW:0] FULL_X = {1'b1, {AW{1'b0}}};
`ifdef TDC_TX_EMPTY_BEAT_EN
    localparam bit EMPTY_BEAT = 1'b1;
`else
    localparam bit EMPTY_BEAT = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]           num;
        logic [2:0][DW-1:0]   t;
        logic [2:0][3:0]      i;
    } frame_t;
    typedef enum logic {A_IDLE, A_OPEN} a_state_t;
    typedef enum logic {T_IDLE, T_SEND} t_state_t;

    a_state_t           a_state_q, a_state_d;
    t_state_t           t_state_q, t_state_d;
    logic [1:0]         hcnt_q, hcnt_d;
    logic [2:0][DW-1:0] slot_t_q, slot_t_d;
    logic [2:0][3:0]    slot_i_q, slot_i_d;
    logic               commit_q, commit_d;
    logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d, rptr_n;
    logic [7:0]         drop_q, drop_d;
    logic [1:0]         b_q, b_d;
    logic [DW-1:0]      odata_q, odata_d;
    logic [3:0]         oint_q, oint_d;
    logic [1:0]         onum_q, onum_d;
    logic               ovalid_q, ovalid_d, olast_q, olast_d, busy_q, busy_d;
    logic               full, empty, hs, pop, push, more, ld, ld_nxt;
    frame_t             fifo_mem [FDEPTH];
    frame_t             head, nxt, ld_f;

    // Assembler: a hit in the shot_end cycle lands in hcnt_d, so it is part of the commit
    always_comb begin
        a_state_d = a_state_q;
        hcnt_d    = hcnt_q;
        slot_t_d  = slot_t_q;
        slot_i_d  = slot_i_q;
        commit_d  = 1'b0;
        if (!tx_en) begin
            a_state_d = A_IDLE;
            hcnt_d    = '0;
        end else if (shot_start) begin
            a_state_d = A_OPEN;
            hcnt_d    = '0;
        end else if (a_state_q == A_OPEN) begin
            if (hit_valid && hcnt_q != 2'd3) begin
                slot_t_d[hcnt_q] = hit_time;
                slot_i_d[hcnt_q] = hit_int;
                hcnt_d           = hcnt_q + 2'd1;
            end
            if (shot_end) begin
                a_state_d = A_IDLE;
                commit_d  = EMPTY_BEAT || hcnt_d != 2'd0;
            end
        end
    end

    assign full   = (wptr_q ^ rptr_q) == FULL_X;
    assign empty  = wptr_q == rptr_q;
    assign hs     = ovalid_q & TDC_Oready;
    assign pop    = hs & olast_q;
    assign push   = commit_q & (~full | pop);
    assign rptr_n = rptr_q + 1'b1;
    assign more   = rptr_n != wptr_q;
    assign head   = fifo_mem[rptr_q[AW-1:0]];
    assign nxt    = fifo_mem[rptr_n[AW-1:0]];

    always_comb begin
        wptr_d = tx_en ? wptr_q + (AW+1)'(push) : '0;
        rptr_d = !tx_en ? '0 : pop ? rptr_n : rptr_q;
        drop_d = (tx_en && commit_q && full && !pop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
    end

    // Transmitter next state
    always_comb begin
        t_state_d = t_state_q;
        b_d       = b_q;
        ld        = 1'b0;
        ld_nxt    = 1'b0;
        if (!tx_en) begin
            t_state_d = T_IDLE;
            b_d       = '0;
        end else if (t_state_q == T_IDLE) begin
            if (!empty) begin
                ld        = 1'b1;
                t_state_d = T_SEND;
                b_d       = '0;
            end
        end else if (hs) begin
            if (!olast_q) begin
                ld  = 1'b1;
                b_d = b_q + 2'd1;
            end else if (more) begin
                ld     = 1'b1;
                ld_nxt = 1'b1;
                b_d    = '0;
            end else begin
                t_state_d = T_IDLE;
            end
        end
    end

    // Transmitter outputs: every beat is registered, held while stalled
    always_comb begin
        ld_f     = ld_nxt ? nxt : head;
        odata_d  = odata_q;
        oint_d   = oint_q;
        onum_d   = onum_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;
        if (!tx_en) begin
            odata_d  = '0;
            oint_d   = '0;
            onum_d   = '0;
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
        end else if (ld) begin
            onum_d   = ld_f.num;
            odata_d  = ld_f.num == 2'd0 ? '0 : ld_f.t[b_d];
            oint_d   = ld_f.num == 2'd0 ? '0 : ld_f.i[b_d];
            olast_d  = ld_f.num == 2'd0 || b_d == ld_f.num - 2'd1;
            ovalid_d = 1'b1;
        end else if (pop) begin
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
        end
        busy_d = a_state_d == A_OPEN || commit_d || wptr_d != rptr_d || ovalid_d;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q[AW-1:0]] <= {hcnt_q, slot_t_q, slot_i_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_state_q <= A_IDLE;
            t_state_q <= T_IDLE;
            hcnt_q    <= '0;
            slot_t_q  <= '0;
            slot_i_q  <= '0;
            commit_q  <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            drop_q    <= '0;
            b_q       <= '0;
            odata_q   <= '0;
            oint_q    <= '0;
            onum_q    <= '0;
            ovalid_q  <= 1'b0;
            olast_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            a_state_q <= a_state_d;
            t_state_q <= t_state_d;
            hcnt_q    <= hcnt_d;
            slot_t_q  <= slot_t_d;
            slot_i_q  <= slot_i_d;
            commit_q  <= commit_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            drop_q    <= drop_d;
            b_q       <= b_d;
            odata_q   <= odata_d;
            oint_q    <= oint_d;
            onum_q    <= onum_d;
            ovalid_q  <= ovalid_d;
            olast_q   <= olast_d;
            busy_q    <= busy_d;
        end
    end

    assign TDC_Odata  = odata_q;
    assign TDC_Oint   = oint_q;
    assign TDC_Onum   = onum_q;
    assign TDC_Ovalid = ovalid_q;
    assign TDC_Olast  = olast_q;
    assign drop_cnt   = drop_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_tdc_stream_tx.sv
// tb_tdc_stream_tx: table vectors, directed corner sequences and random shots against a queue-based shot model.
module tb_tdc_stream_tx;
    localparam int FDEPTH = 2;
    localparam int DW     = 15;
`ifdef TDC_TX_EMPTY_BEAT_EN
    localparam bit EMPTY_EN = 1'b1;
`else
    localparam bit EMPTY_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn, tx_en, shot_start, shot_end, hit_valid, TDC_Oready;
    logic [DW-1:0] hit_time, TDC_Odata;
    logic [3:0]    hit_int, TDC_Oint;
    logic [1:0]    TDC_Onum;
    logic          TDC_Ovalid, TDC_Olast, busy;
    logic [7:0]    drop_cnt;

    tdc_stream_tx #(.FDEPTH(FDEPTH), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .tx_en(tx_en), .shot_start(shot_start), .shot_end(shot_end),
        .hit_valid(hit_valid), .hit_time(hit_time), .hit_int(hit_int),
        .TDC_Odata(TDC_Odata), .TDC_Oint(TDC_Oint), .TDC_Onum(TDC_Onum), .TDC_Ovalid(TDC_Ovalid),
        .TDC_Olast(TDC_Olast), .TDC_Oready(TDC_Oready), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [3:0]    i;
        logic [1:0]    n;
        logic          l;
    } beat_t;
    typedef struct {
        int            nh;
        bit            he;
        logic [DW-1:0] t [5];
        logic [3:0]    i [5];
        logic [1:0]    en;
        int            eb;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit rnd_rdy = 1'b0;
    beat_t exp_q [$];
    beat_t cap_q [$];
    beat_t pend_q [$];
    logic [DW-1:0] m_t [$];
    logic [3:0]    m_i [$];
    bit  m_open, m_pend, p_stall;
    int  m_occ, m_drop;
    logic [31:0] p_out;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Shot-level reference: everything computed here is what the upcoming edge must do
    always @(negedge clk) begin : model
        beat_t e, b;
        if (!rstn) begin
            m_open = 0; m_pend = 0; m_occ = 0; m_drop = 0; p_stall = 0;
            exp_q.delete(); pend_q.delete(); m_t.delete(); m_i.delete();
        end else begin
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("busy", 32'(busy), 32'(m_open || m_pend || m_occ != 0));
            if (p_stall) chk("stall_stable", {9'd0, TDC_Ovalid, TDC_Olast, TDC_Onum, TDC_Oint, TDC_Odata}, p_out);
            p_stall = TDC_Ovalid && !TDC_Oready && tx_en;
            p_out = {9'd0, TDC_Ovalid, TDC_Olast, TDC_Onum, TDC_Oint, TDC_Odata};
            if (TDC_Ovalid && TDC_Oready) begin
                b = '{d: TDC_Odata, i: TDC_Oint, n: TDC_Onum, l: TDC_Olast};
                cap_q.push_back(b);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_beat: got data %0h num %0d, expected no beat at %0t", b.d, b.n, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {9'd0, b.l, b.n, b.i, b.d}, {9'd0, e.l, e.n, e.i, e.d});
                    if (e.l) m_occ--;
                end
            end
            if (!tx_en) begin
                m_open = 0; m_pend = 0; m_occ = 0;
                exp_q.delete(); pend_q.delete(); m_t.delete(); m_i.delete();
            end else begin
                if (m_pend) begin
                    if (m_occ < FDEPTH) begin
                        m_occ++;
                        foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
                    end else if (m_drop < 255) m_drop++;
                    m_pend = 0;
                    pend_q.delete();
                end
                if (shot_start) begin
                    m_open = 1; m_t.delete(); m_i.delete();
                end else if (m_open) begin
                    if (hit_valid && m_t.size() < 3) begin
                        m_t.push_back(hit_time); m_i.push_back(hit_int);
                    end
                    if (shot_end) begin
                        m_open = 0;
                        if (m_t.size() > 0) begin
                            m_pend = 1;
                            foreach (m_t[k]) pend_q.push_back('{d: m_t[k], i: m_i[k], n: 2'(m_t.size()), l: k == m_t.size() - 1});
                        end else if (EMPTY_EN) begin
                            m_pend = 1;
                            pend_q.push_back('{d: '0, i: '0, n: 2'd0, l: 1'b1});
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) TDC_Oready = $urandom_range(0, 3) != 0;
    endtask

    task automatic step(input bit ss, input bit se, input bit hv, input logic [DW-1:0] t, input logic [3:0] i);
        shot_start = ss; shot_end = se; hit_valid = hv; hit_time = t; hit_int = i;
        tick();
        shot_start = 0; shot_end = 0; hit_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, '0, '0);
    endtask

    task automatic shot(input vec_t v);
        step(1, 0, 0, '0, '0);
        for (int k = 0; k < v.nh; k++) step(0, v.he && k == v.nh - 1, 1, v.t[k], v.i[k]);
        if (!(v.he && v.nh > 0)) step(0, 1, 0, '0, '0);
    endtask

    task automatic drain();
        int k = 0;
        TDC_Oready = 1;
        while ((busy || exp_q.size() != 0) && k < 500) begin
            idle(1);
            k++;
        end
        chk("drain_timeout", 32'(k < 500), 32'd1);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!TDC_Ovalid && k < 50) begin
            idle(1);
            k++;
        end
        chk("valid_timeout", 32'(TDC_Ovalid), 32'd1);
    endtask

    function automatic vec_t mk(input int nh, input bit he, input logic [1:0] en, input int eb, input int seed);
        vec_t v;
        v.nh = nh; v.he = he; v.en = en; v.eb = eb;
        for (int k = 0; k < 5; k++) begin
            v.t[k] = DW'(seed * 256 + k * 17 + 1);
            v.i[k] = 4'(seed + k + 1);
        end
        return v;
    endfunction

    initial begin
        vec_t v;
        rstn = 0; tx_en = 1; TDC_Oready = 1;
        shot_start = 0; shot_end = 0; hit_valid = 0; hit_time = '0; hit_int = '0;
        vecs[0] = mk(2, 0, 2'd2, 2, 0);
        vecs[0].t[0] = 15'h1234; vecs[0].i[0] = 4'd5; vecs[0].t[1] = 15'h0456; vecs[0].i[1] = 4'd9;
        vecs[1] = mk(5, 0, 2'd3, 3, 1);
        vecs[2] = mk(1, 0, 2'd1, 1, 2);
        vecs[3] = mk(3, 1, 2'd3, 3, 3);
        vecs[4] = mk(0, 0, 2'd0, EMPTY_EN ? 1 : 0, 4);
        vecs[4].t[0] = '0; vecs[4].i[0] = '0;
        vecs[5] = mk(4, 1, 2'd3, 3, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(TDC_Ovalid), 0);
        chk("rst_outs", {TDC_Olast, TDC_Onum, TDC_Oint, TDC_Odata}, 0);
        chk("rst_drop_busy", {drop_cnt, busy}, 0);
        rstn = 1;
        idle(2);

        foreach (vecs[n]) begin
            cap_q.delete();
            shot(vecs[n]);
            drain();
            chk($sformatf("vec%0d_nbeats", n), cap_q.size(), vecs[n].eb);
            for (int k = 0; k < vecs[n].eb && k < cap_q.size(); k++) begin
                chk($sformatf("vec%0d_beat%0d", n, k), {cap_q[k].l, cap_q[k].n, cap_q[k].i, cap_q[k].d},
                    {k == vecs[n].eb - 1, vecs[n].en, vecs[n].i[k], vecs[n].t[k]});
            end
        end

        // Latency from shot_end and back-to-back beats
        step(1, 0, 0, '0, '0);
        step(0, 0, 1, 15'h1234, 4'd5);
        step(0, 0, 1, 15'h0456, 4'd9);
        step(0, 1, 0, '0, '0);
        chk("lat_n", 32'(TDC_Ovalid), 0);
        idle(1);
        chk("lat_n1", 32'(TDC_Ovalid), 0);
        idle(1);
        chk("lat_n2", {TDC_Ovalid, TDC_Olast, TDC_Onum, TDC_Odata}, {1'b1, 1'b0, 2'd2, 15'h1234});
        idle(1);
        chk("lat_n3", {TDC_Ovalid, TDC_Olast, TDC_Onum, TDC_Odata}, {1'b1, 1'b1, 2'd2, 15'h0456});
        drain();

        // Ten-cycle stall mid-burst
        cap_q.delete();
        shot(mk(3, 0, 2'd3, 3, 6));
        wait_valid();
        idle(1);
        TDC_Oready = 0;
        idle(10);
        chk("stall_valid", {TDC_Ovalid, TDC_Odata}, {1'b1, vecs[0].t[0] & 15'h0 | DW'(6 * 256 + 17 + 1)});
        drain();
        chk("stall_nbeats", cap_q.size(), 3);

        // Overflow with sink stalled
        TDC_Oready = 0;
        cap_q.delete();
        for (int s = 0; s < 4; s++) begin
            v = mk(1, 0, 2'd1, 1, 8 + s);
            shot(v);
        end
        idle(4);
        chk("ovf_drop", 32'(drop_cnt), 2);
        drain();
        chk("ovf_nbeats", cap_q.size(), 2);
        if (cap_q.size() == 2) chk("ovf_order", {cap_q[0].d, cap_q[1].d}, {DW'(8 * 256 + 1), DW'(9 * 256 + 1)});

        // Enable dropped mid-burst
        TDC_Oready = 0;
        shot(mk(2, 0, 2'd2, 2, 12));
        shot(mk(2, 0, 2'd2, 2, 13));
        idle(3);
        TDC_Oready = 1;
        idle(1);
        tx_en = 0;
        idle(1);
        chk("txen_valid", 32'(TDC_Ovalid), 0);
        idle(2);
        chk("txen_busy", 32'(busy), 0);
        tx_en = 1;
        idle(2);
        cap_q.delete();
        v = mk(1, 0, 2'd1, 1, 0);
        v.t[0] = 15'h7abc; v.i[0] = 4'd3;
        shot(v);
        drain();
        chk("txen_nbeats", cap_q.size(), 1);
        if (cap_q.size() == 1) chk("txen_beat", {cap_q[0].l, cap_q[0].n, cap_q[0].i, cap_q[0].d}, {1'b1, 2'd1, 4'd3, 15'h7abc});

        // Random shots with random back-pressure
        rnd_rdy = 1;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 5) == 0) begin
                step(1, 0, 0, '0, '0);
                step(0, 0, 1, DW'($urandom), 4'($urandom));
            end
            v.nh = $urandom_range(0, 5);
            v.he = v.nh > 0 && $urandom_range(0, 1) == 1;
            for (int k = 0; k < 5; k++) begin
                v.t[k] = DW'($urandom);
                v.i[k] = 4'($urandom);
            end
            shot(v);
            idle($urandom_range(0, 4));
        end
        rnd_rdy = 0;
        drain();

        // Asynchronous reset mid-burst
        TDC_Oready = 0;
        shot(mk(1, 0, 2'd1, 1, 14));
        idle(4);
        chk("arst_pre", 32'(TDC_Ovalid), 1);
        rstn = 0;
        #1;
        chk("arst_valid", 32'(TDC_Ovalid), 0);
        tick();
        rstn = 1;
        TDC_Oready = 1;
        cap_q.delete();
        idle(5);
        chk("arst_lost", cap_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
